// File: rtl/cam_pwr_seq_pkg.sv
// Shared types and default timing for the camera power sequencer.
package cam_pwr_seq_pkg;

  typedef enum logic [2:0] {
    LOCK_WAIT,
    PWDN_HOLD,
    RST_HOLD,
    SETTLE,
    INIT_REQ,
    INIT_WAIT,
    READY,
    FAULT
  } state_e;

  localparam int unsigned DEF_LOCK_STABLE = 1024;
  localparam int unsigned DEF_T_PWDN      = 27000;
  localparam int unsigned DEF_T_RST       = 27000;
  localparam int unsigned DEF_T_SETTLE    = 540000;
  localparam int unsigned DEF_WDOG_CYCLES = 27000000;
  localparam int unsigned RETRY_MAX       = 3;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_pwr_seq_if.sv
// Request/ack/done handshake between the sequencer and the camera config engine.
interface cam_pwr_seq_if;
  logic init_req;
  logic init_ack;
  logic init_done;

  modport master (output init_req, input init_ack, input init_done);
  modport slave  (input init_req, output init_ack, output init_done);
endinterface

// File: rtl/cam_pwr_seq_lock_qual.sv
// PLL lock synchronizer and stability qualifier: lock_ok rises on the
// LOCK_STABLE-th consecutive synchronized-high cycle.
module lock_qual
  import cam_pwr_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  output logic lock_sync,
  output logic lock_ok
);

  localparam int unsigned CW = $clog2(LOCK_STABLE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_STABLE - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], pll_lock};
    cnt_d  = cnt_q;
    if (!sync_q[1])
      cnt_d = '0;
    else if (cnt_q != CNT_LAST)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  // Counter saturates one short of LOCK_STABLE; the current high cycle completes the count.
  assign lock_sync = sync_q[1];
  assign lock_ok   = sync_q[1] && (cnt_q == CNT_LAST);

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: lock qualify, power-down, reset, settle, config handshake.
// Optional init watchdog with retries enabled by CAM_PWR_SEQ_WDOG_EN.
module cam_pwr_seq
  import cam_pwr_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int unsigned T_PWDN      = DEF_T_PWDN,
  parameter int unsigned T_RST       = DEF_T_RST,
  parameter int unsigned T_SETTLE    = DEF_T_SETTLE,
  parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  cam_pwr_seq_if.master        init_if,
  output logic                 cam_pwdn,
  output logic                 cam_rst_n,
  output logic                 ready,
  output logic                 fault
);

  localparam int unsigned TW = $clog2(max2(max2(T_PWDN, T_RST), max2(T_SETTLE, WDOG_CYCLES))) + 1;
  localparam logic [TW-1:0] PWDN_LAST   = TW'(T_PWDN - 1);
  localparam logic [TW-1:0] RST_LAST    = TW'(T_RST - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(T_SETTLE - 1);

  logic lock_sync, lock_ok;

  lock_qual #(.LOCK_STABLE(LOCK_STABLE)) u_lock_qual (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .lock_sync(lock_sync),
    .lock_ok  (lock_ok)
  );

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          cam_pwdn_q, cam_pwdn_d;
  logic          cam_rst_n_q, cam_rst_n_d;
  logic          init_req_q, init_req_d;
  logic          ready_q, ready_d;

`ifdef CAM_PWR_SEQ_WDOG_EN
  localparam logic [TW-1:0] WDOG_LAST = TW'(WDOG_CYCLES - 1);
  logic [1:0] retry_q, retry_d;
  logic       fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
`ifdef CAM_PWR_SEQ_WDOG_EN
    retry_d = retry_q;
`endif
    case (state_q)
      LOCK_WAIT: begin
        tmr_d = '0;
        if (lock_ok) state_d = PWDN_HOLD;
      end
      PWDN_HOLD: begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_q == PWDN_LAST) begin
          state_d = RST_HOLD;
          tmr_d   = '0;
        end
      end
      RST_HOLD: begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_q == RST_LAST) begin
          state_d = SETTLE;
          tmr_d   = '0;
        end
      end
      SETTLE: begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_q == SETTLE_LAST) begin
          state_d = INIT_REQ;
          tmr_d   = '0;
        end
      end
      INIT_REQ: begin
        tmr_d = '0;
        if (init_if.init_ack) state_d = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (init_if.init_done) begin
          state_d = READY;
          tmr_d   = '0;
        end
`ifdef CAM_PWR_SEQ_WDOG_EN
        else if (tmr_q == WDOG_LAST) begin
          tmr_d = '0;
          if (retry_q == 2'(RETRY_MAX - 1)) begin
            state_d = FAULT;
          end else begin
            state_d = PWDN_HOLD;
            retry_d = retry_q + 2'd1;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
`endif
      end
      READY: begin
`ifdef CAM_PWR_SEQ_WDOG_EN
        retry_d = '0;
`endif
      end
      FAULT: ;
      default: state_d = LOCK_WAIT;
    endcase

    // Lock loss overrides every other transition.
    if (!lock_sync) begin
      state_d = LOCK_WAIT;
      tmr_d   = '0;
`ifdef CAM_PWR_SEQ_WDOG_EN
      retry_d = '0;
`endif
    end

    // Outputs are decoded from the next state so they register alongside it.
    cam_pwdn_d  = (state_d == LOCK_WAIT) || (state_d == PWDN_HOLD) || (state_d == FAULT);
    cam_rst_n_d = (state_d == SETTLE) || (state_d == INIT_REQ) ||
                  (state_d == INIT_WAIT) || (state_d == READY);
    init_req_d  = (state_d == INIT_REQ);
    ready_d     = (state_d == READY);
`ifdef CAM_PWR_SEQ_WDOG_EN
    fault_d     = (state_d == FAULT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOCK_WAIT;
      tmr_q       <= '0;
      cam_pwdn_q  <= 1'b1;
      cam_rst_n_q <= 1'b0;
      init_req_q  <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cam_pwdn_q  <= cam_pwdn_d;
      cam_rst_n_q <= cam_rst_n_d;
      init_req_q  <= init_req_d;
      ready_q     <= ready_d;
    end
  end

`ifdef CAM_PWR_SEQ_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
      fault_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign cam_pwdn         = cam_pwdn_q;
  assign cam_rst_n        = cam_rst_n_q;
  assign init_if.init_req = init_req_q;
  assign ready            = ready_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Scoreboard bench for cam_pwr_seq: expected output transitions are queued with
// their cycle when stimulus is driven and matched as the outputs change.
module tb_cam_pwr_seq;
  import cam_pwr_seq_pkg::*;

  localparam int unsigned LS = 4, TP = 8, TR = 16, TS = 32, WD = 64;

  typedef struct {
    string      tag;
    logic [4:0] vec;   // {cam_pwdn, cam_rst_n, init_req, ready, fault}
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_lock = 1'b0;
  logic cam_pwdn, cam_rst_n, ready, fault;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  logic [4:0] exp_cur = 5'b10000;
  logic [4:0] prev_vec = 5'b10000;

  cam_pwr_seq_if init_if();

  cam_pwr_seq #(
    .LOCK_STABLE(LS), .T_PWDN(TP), .T_RST(TR), .T_SETTLE(TS), .WDOG_CYCLES(WD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .init_if  (init_if.master),
    .cam_pwdn (cam_pwdn),
    .cam_rst_n(cam_rst_n),
    .ready    (ready),
    .fault    (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [4:0] out_vec = {cam_pwdn, cam_rst_n, init_if.init_req, ready, fault};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input string tag, input logic [4:0] v, input int c);
    exp_t e;
    e.tag = tag; e.vec = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && out_vec !== prev_vec) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", out_vec, exp_cur);
      end else begin
        e = exp_q.pop_front();
        check(e.tag, out_vec, e.vec);
        check({e.tag, "_cyc"}, cyc, e.cyc);
        exp_cur = e.vec;
      end
      prev_vec = out_vec;
    end
  end

  // Lock sequencing from a lock edge (or reset release with lock high) at cycle c.
  task automatic push_seq(input string pfx, input int c);
    push({pfx, "_pwdn_fall"}, 5'b00000, c + 2 + LS + TP);
    push({pfx, "_rstn_rise"}, 5'b01000, c + 2 + LS + TP + TR);
    push({pfx, "_req_rise"},  5'b01100, c + 2 + LS + TP + TR + TS);
  endtask

  task automatic wait_bit(input string tag, input int idx, input logic val, input int budget);
    int n = 0;
    while (out_vec[idx] !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, out_vec[idx], val);
  endtask

  task automatic do_ack(input int dly, output int a);
    wait_bit("wait_req", 2, 1'b1, 300);
    repeat (dly) @(negedge clk);
    init_if.init_ack = 1'b1;
    a = cyc;
    push("req_fall", 5'b01000, a + 1);
    @(negedge clk);
    init_if.init_ack = 1'b0;
  endtask

  task automatic drop_lock(input string tag);
    exp_q.delete();
    pll_lock = 1'b0;
    init_if.init_done = 1'b0;
    push(tag, 5'b10000, cyc + 3);
  endtask

  initial begin
    int a;
    init_if.init_ack  = 1'b0;
    init_if.init_done = 1'b0;
    #3 rst_n = 1'b0;
    #1 check("reset_outputs", out_vec, 5'b10000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Short lock glitch: three synchronized-high cycles must not qualify.
    pll_lock = 1'b1;
    repeat (3) @(negedge clk);
    pll_lock = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_outputs", out_vec, 5'b10000);

    // Full power-up with delayed ack and done.
    pll_lock = 1'b1;
    push_seq("run1", cyc);
    do_ack(10, a);
    repeat (5) @(negedge clk);
    init_if.init_done = 1'b1;
    push("ready_rise", 5'b01010, cyc + 1);
    repeat (10) @(negedge clk);

    drop_lock("drop_in_ready");
    repeat (8) @(negedge clk);

    // Relock; stray ack/done during RST_HOLD are ignored; lock lost in SETTLE.
    pll_lock = 1'b1;
    push_seq("run2", cyc);
    wait_bit("wait_pwdn_fall2", 4, 1'b0, 100);
    init_if.init_ack = 1'b1;
    init_if.init_done = 1'b1;
    @(negedge clk);
    init_if.init_ack = 1'b0;
    init_if.init_done = 1'b0;
    wait_bit("wait_rstn_rise2", 3, 1'b1, 100);
    repeat (5) @(negedge clk);
    drop_lock("drop_in_settle");
    repeat (8) @(negedge clk);

    // Asynchronous reset in RST_HOLD, then full requalification.
    pll_lock = 1'b1;
    push_seq("run3", cyc);
    wait_bit("wait_pwdn_fall3", 4, 1'b0, 100);
    repeat (3) @(negedge clk);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", out_vec, 5'b10000);
    push("async_reset", 5'b10000, cyc + 1);
    @(negedge clk);
    rst_n = 1'b1;
    push_seq("run4", cyc);
    do_ack(2, a);

`ifdef CAM_PWR_SEQ_WDOG_EN
    for (int k = 0; k < 3; k++) begin
      if (k > 0) do_ack(2, a);
      if (k < 2) begin
        push("wdog_retry", 5'b10000, a + 1 + WD);
        push_seq("retry", a + 1 + WD - 2 - LS);
      end else begin
        push("wdog_fault", 5'b10001, a + 1 + WD);
      end
    end
    wait_bit("wait_fault", 0, 1'b1, 200);
    repeat (50) @(negedge clk);
    check("fault_held", out_vec, 5'b10001);
`else
    repeat (150) @(negedge clk);
    check("init_wait_no_fault", out_vec, 5'b01000);
`endif

    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_pwr_seq.md
CAM_PWR_SEQ -- requirements
Module: cam_pwr_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE, default 1024: consecutive synchronized PLL-lock-high cycles required before sequencing starts.
REQ-002 SHALL have parameter T_PWDN, default 27000: cycles the camera is held powered down (pwdn=1, rst_n=0).
REQ-003 SHALL have parameter T_RST, default 27000: cycles with power up but reset asserted.
REQ-004 SHALL have parameter T_SETTLE, default 540000: cycles after reset release before config is requested.
REQ-005 SHALL have parameter WDOG_CYCLES, default 27000000: init_done timeout; used only with the watchdog macro.
REQ-006 All timing parameters SHALL be >=1; counter width SHALL be $clog2 of the largest, plus 1.
REQ-007 clk  input  1  sequencer clock (PLL output domain).
REQ-008 rst_n  input  1  reset; asynchronous, active-low.
REQ-009 pll_lock  input  1  raw PLL lock, asynchronous to clk.
REQ-010 init_ack  input  1  config engine accepted the request.
REQ-011 init_done  input  1  config engine finished writing the camera registers (level).
REQ-012 cam_pwdn  output  1  camera power-down pin, 1 = powered down.
REQ-013 cam_rst_n  output  1  camera reset pin, active-low.
REQ-014 init_req  output  1  request to the config engine, level.
REQ-015 ready  output  1  camera powered, configured, usable.
REQ-016 fault  output  1  init retries exhausted.

Function
REQ-017 pll_lock SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value.
REQ-018 FSM states: LOCK_WAIT, PWDN_HOLD, RST_HOLD, SETTLE, INIT_REQ, INIT_WAIT, READY, FAULT.
REQ-019 LOCK_WAIT: stable counter increments while synced lock=1, clears on 0; on reaching LOCK_STABLE -> PWDN_HOLD.
REQ-020 PWDN_HOLD: cam_pwdn=1, cam_rst_n=0, exactly T_PWDN cycles, then -> RST_HOLD.
REQ-021 RST_HOLD: cam_pwdn=0, cam_rst_n=0, exactly T_RST cycles, then -> SETTLE.
REQ-022 SETTLE: cam_pwdn=0, cam_rst_n=1, exactly T_SETTLE cycles, then -> INIT_REQ.
REQ-023 INIT_REQ: init_req=1 held until the cycle init_ack=1 is sampled; next cycle init_req=0, state INIT_WAIT.
REQ-024 INIT_WAIT: on init_done=1 -> READY; ready asserts one cycle later, registered.
REQ-025 READY: ready=1 held while synced lock=1.
REQ-026 Synced lock=0 in any state other than LOCK_WAIT SHALL force LOCK_WAIT next cycle: cam_pwdn=1, cam_rst_n=0, init_req=0, ready=0, fault=0, counters cleared; takes priority over all other transitions.
REQ-027 init_ack or init_done outside their states SHALL be ignored.
REQ-028 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 On rst_n=0: state LOCK_WAIT, cam_pwdn=1, cam_rst_n=0, init_req=0, ready=0, fault=0, synchronizer and counters 0.
REQ-030 Reset mid-sequence SHALL restart from LOCK_WAIT with the full LOCK_STABLE qualification.

Configuration
REQ-031 Macro CAM_PWR_SEQ_WDOG_EN defined: INIT_WAIT counts cycles; at WDOG_CYCLES without init_done -> PWDN_HOLD and retry count +1; after the 3rd timeout -> FAULT (fault=1, cam_pwdn=1, cam_rst_n=0) until reset or lock loss; retry count clears on READY, reset, lock loss.
REQ-032 Macro undefined: INIT_WAIT waits indefinitely, no watchdog counter or retry logic, fault tied 0.

Structure
REQ-033 Package cam_pwr_seq_pkg SHALL hold the state enum and the default timing constants.
REQ-034 Sub-module lock_qual SHALL implement the 2-FF synchronizer plus LOCK_STABLE counter, outputting lock_ok and synced lock.

Verification (LOCK_STABLE=4, T_PWDN=8, T_RST=16, T_SETTLE=32, WDOG_CYCLES=64)
REQ-035 pll_lock rises at cycle 0 -> cam_pwdn falls at cycle 2+4+8 (+-1 registration), cam_rst_n rises 16 cycles later, init_req rises 32 cycles after that.
REQ-036 pll_lock glitch high 3 cycles then low -> state stays LOCK_WAIT, outputs unchanged.
REQ-037 init_ack delayed 10 cycles -> init_req high exactly until ack sampled; init_done 5 cycles later -> ready=1 next cycle.
REQ-038 pll_lock drops in SETTLE and in READY -> within 3 cycles cam_pwdn=1, cam_rst_n=0, ready=0; relock replays full sequence.
REQ-039 With CAM_PWR_SEQ_WDOG_EN, init_done never asserted -> three 64-cycle timeouts each rerunning PWDN_HOLD, then fault=1 stable; without the macro state remains INIT_WAIT, fault=0.
REQ-040 rst_n asserted asynchronously mid-RST_HOLD -> all outputs at reset values immediately, without a clock edge.
